// File: rtl/rv32i_lsu_if.sv
// rtl/rv32i_lsu_if.sv - request/response and data memory signals of the rv32i load/store unit
interface rv32i_lsu_if #(
  parameter int DMEM_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic [1:0]            resp_error;
  logic                  data_mem_req;
  logic [DMEM_WIDTH-1:0] data_mem_addr;
  logic [3:0]            data_mem_wmask;
  logic [31:0]           data_mem_write;
  logic [31:0]           data_mem_read;
  logic                  data_mem_valid;

  // master: core plus data memory; slave: the load/store unit
  modport master (
    output req_valid, req_op, req_funct3, req_addr, req_wdata, data_mem_read, data_mem_valid,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  data_mem_req, data_mem_addr, data_mem_wmask, data_mem_write
  );

  modport slave (
    input  req_valid, req_op, req_funct3, req_addr, req_wdata, data_mem_read, data_mem_valid,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output data_mem_req, data_mem_addr, data_mem_wmask, data_mem_write
  );
endinterface

// File: rtl/rv32i_lsu.sv
// rtl/rv32i_lsu.sv - rv32i load/store unit: one request in, one word-aligned memory access, one response out
module rv32i_lsu #(
  parameter int DMEM_WIDTH = 16,
  parameter int MAX_WAIT   = 3
) (
  input logic        clk,
  input logic        reset,
  rv32i_lsu_if.slave bus
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          is_load;
  logic [2:0]    funct3;
  logic [1:0]    lane;

  logic          illegal;
  logic          misaligned;
  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic [31:0]   shifted;
  logic [31:0]   ld_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:DMEM_WIDTH];

  always_comb begin
    illegal = 1'b1;
    if (bus.req_op == 2'b01)
      illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (bus.req_op == 2'b10)
      illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  end

  // store lane steering; misaligned cases never reach ACCESS so no lane can wrap
  always_comb begin
    st_mask = 4'b1111;
    st_data = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << bus.req_addr[1:0];
        st_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << bus.req_addr[1:0];
        st_data = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = bus.data_mem_read >> {lane, 3'b000};
    case (funct3)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      wait_cnt           <= '0;
      is_load            <= 1'b0;
      funct3             <= 3'b000;
      lane               <= 2'b00;
      bus.req_ready      <= 1'b0;
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= '0;
      bus.resp_error     <= 2'b00;
      bus.data_mem_req   <= 1'b0;
      bus.data_mem_addr  <= '0;
      bus.data_mem_wmask <= 4'b0000;
      bus.data_mem_write <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            is_load       <= (bus.req_op == 2'b01);
            funct3        <= bus.req_funct3;
            lane          <= bus.req_addr[1:0];
            if (illegal || misaligned) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= illegal ? 2'b11 : 2'b01;
            end else begin
              state              <= ACCESS;
              bus.data_mem_req   <= 1'b1;
              bus.data_mem_addr  <= {bus.req_addr[DMEM_WIDTH-1:2], 2'b00};
              bus.data_mem_wmask <= (bus.req_op == 2'b10) ? st_mask : 4'b0000;
              bus.data_mem_write <= (bus.req_op == 2'b10) ? st_data : 32'd0;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        ACCESS: begin
          state              <= WAIT;
          wait_cnt           <= '0;
          bus.data_mem_req   <= 1'b0;
          bus.data_mem_wmask <= 4'b0000;
        end
        WAIT: begin
          // a completion on the limit cycle still beats the timeout
          if (bus.data_mem_valid) begin
            state             <= RESP;
            bus.resp_valid    <= 1'b1;
            bus.resp_rdata    <= is_load ? ld_data : 32'd0;
            bus.resp_error    <= 2'b00;
            bus.data_mem_addr <= '0;
            bus.data_mem_write <= '0;
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            state             <= RESP;
            bus.resp_valid    <= 1'b1;
            bus.resp_error    <= 2'b10;
            bus.data_mem_addr <= '0;
            bus.data_mem_write <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
          bus.resp_rdata <= '0;
          bus.resp_error <= 2'b00;
          bus.req_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule
